// File: rtl/memory_accessor.sv
// ---------------------------------------------------------------------------
// memory_accessor
//
// Memory-access functional unit of the dataflow core. It accepts one MA
// packet and issues a single memory request: a read (PEEK) or a write (POKE).
// It then waits for the memory reply word and emits a worker result that
// carries the reply to the packet's destination and color. Only one
// operation is in flight at a time.
//
// Ports (all transfers are VALID && READY at a rising CLK edge):
//   CLK, RST                  clock; synchronous active-low reset
//   RECEIVE_PC_VALID/DATA     incoming MA packet
//   RECEIVE_PC_READY          unit idle and able to take a packet
//   SEND_WR_VALID/DATA        worker result {dest_option, dest_addr, color, word}
//   SEND_WR_READY             downstream accepts the result
//   MEM_SEND_ADDR_VALID/ADDR  memory request and its address (packet data1)
//   MEM_SEND_DATA_VALID/DATA  request is a write, with write data (packet data2)
//   MEM_SEND_READY            memory accepts the request
//   MEM_RECEIVE_VALID/DATA    memory reply word
//   MEM_RECEIVE_READY         unit is waiting for the reply
//
// Every output comes straight from a flop. Each handshake output is loaded
// from the next state, so it is valid in the same cycle as its state and is
// 0 throughout reset.
// ---------------------------------------------------------------------------
module memory_accessor #(
    parameter logic [9:0] MA_POKE = 10'd1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         RECEIVE_PC_VALID,
    input  logic [178:0] RECEIVE_PC_DATA,
    output logic         RECEIVE_PC_READY,
    output logic         SEND_WR_VALID,
    output logic [66:0]  SEND_WR_DATA,
    input  logic         SEND_WR_READY,
    output logic         MEM_SEND_ADDR_VALID,
    output logic [31:0]  MEM_SEND_ADDR,
    output logic         MEM_SEND_DATA_VALID,
    output logic [31:0]  MEM_SEND_DATA,
    input  logic         MEM_SEND_READY,
    input  logic         MEM_RECEIVE_VALID,
    input  logic [31:0]  MEM_RECEIVE_DATA,
    output logic         MEM_RECEIVE_READY
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESULT = 2'd3;

    // Packet fields, MSB..LSB: opcode, subop, data1..data4, dest_option, dest_addr, color
    logic [9:0]  pkt_subop_s;
    logic [31:0] pkt_data1_s;
    logic [31:0] pkt_data2_s;
    logic [2:0]  pkt_dest_option_s;
    logic [15:0] pkt_dest_addr_s;
    logic [15:0] pkt_color_s;
    logic        unused_pkt_s;

    assign pkt_subop_s       = RECEIVE_PC_DATA[172:163];
    assign pkt_data1_s       = RECEIVE_PC_DATA[162:131];
    assign pkt_data2_s       = RECEIVE_PC_DATA[130:99];
    assign pkt_dest_option_s = RECEIVE_PC_DATA[34:32];
    assign pkt_dest_addr_s   = RECEIVE_PC_DATA[31:16];
    assign pkt_color_s       = RECEIVE_PC_DATA[15:0];
    // The opcode is already consumed by upstream routing; data3/data4 are unused by MA.
    assign unused_pkt_s      = ^{RECEIVE_PC_DATA[178:173], RECEIVE_PC_DATA[98:35]};

    logic [1:0]  state_q,       state_d;
    logic        pc_ready_q,    pc_ready_d;
    logic        addr_valid_q,  addr_valid_d;
    logic        wdata_valid_q, wdata_valid_d;
    logic        rx_ready_q,    rx_ready_d;
    logic        wr_valid_q,    wr_valid_d;
    logic [31:0] addr_q,        addr_d;
    logic [31:0] wdata_q,       wdata_d;
    logic        is_poke_q,     is_poke_d;
    logic [2:0]  dest_option_q, dest_option_d;
    logic [15:0] dest_addr_q,   dest_addr_d;
    logic [15:0] color_q,       color_d;
    logic [31:0] reply_q,       reply_d;

    // Next-state and capture logic; handshakes qualify on the registered ready/valid outputs
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        is_poke_d     = is_poke_q;
        dest_option_d = dest_option_q;
        dest_addr_d   = dest_addr_q;
        color_d       = color_q;
        reply_d       = reply_q;
        case (state_q)
            ST_IDLE: begin
                if (pc_ready_q && RECEIVE_PC_VALID) begin
                    addr_d        = pkt_data1_s;
                    wdata_d       = pkt_data2_s;
                    // Any subop other than POKE is executed as a PEEK.
                    is_poke_d     = (pkt_subop_s == MA_POKE);
                    dest_option_d = pkt_dest_option_s;
                    dest_addr_d   = pkt_dest_addr_s;
                    color_d       = pkt_color_s;
                    state_d       = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (addr_valid_q && MEM_SEND_READY) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (rx_ready_q && MEM_RECEIVE_VALID) begin
                    reply_d = MEM_RECEIVE_DATA;
                    state_d = ST_RESULT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESULT: begin
                if (wr_valid_q && SEND_WR_READY) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESULT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the next state so they register alongside it
    always_comb begin
        pc_ready_d    = (state_d == ST_IDLE);
        addr_valid_d  = (state_d == ST_REQ);
        wdata_valid_d = (state_d == ST_REQ) && is_poke_d;
        rx_ready_d    = (state_d == ST_WAIT);
        wr_valid_d    = (state_d == ST_RESULT);
    end

    // State and output registers; reset aborts any operation and clears every output
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q       <= ST_IDLE;
            pc_ready_q    <= 1'b0;
            addr_valid_q  <= 1'b0;
            wdata_valid_q <= 1'b0;
            rx_ready_q    <= 1'b0;
            wr_valid_q    <= 1'b0;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            is_poke_q     <= 1'b0;
            dest_option_q <= 3'd0;
            dest_addr_q   <= 16'd0;
            color_q       <= 16'd0;
            reply_q       <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_ready_q    <= pc_ready_d;
            addr_valid_q  <= addr_valid_d;
            wdata_valid_q <= wdata_valid_d;
            rx_ready_q    <= rx_ready_d;
            wr_valid_q    <= wr_valid_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            is_poke_q     <= is_poke_d;
            dest_option_q <= dest_option_d;
            dest_addr_q   <= dest_addr_d;
            color_q       <= color_d;
            reply_q       <= reply_d;
        end
    end

    assign RECEIVE_PC_READY    = pc_ready_q;
    assign MEM_SEND_ADDR_VALID = addr_valid_q;
    assign MEM_SEND_ADDR       = addr_q;
    assign MEM_SEND_DATA_VALID = wdata_valid_q;
    assign MEM_SEND_DATA       = wdata_q;
    assign MEM_RECEIVE_READY   = rx_ready_q;
    assign SEND_WR_VALID       = wr_valid_q;
    assign SEND_WR_DATA        = {dest_option_q, dest_addr_q, color_q, reply_q};

endmodule

// File: tb/tb_memory_accessor.sv
// ---------------------------------------------------------------------------
// tb_memory_accessor
//
// Directed bench for memory_accessor. The bench drives inputs and samples
// outputs 1 ns after each rising edge. Expected values come from the packet
// fields and reply words that the bench chooses itself.
// ---------------------------------------------------------------------------
module tb_memory_accessor;

    localparam logic [9:0] MA_PEEK = 10'd0;
    localparam logic [9:0] MA_POKE = 10'd1;

    logic         CLK = 1'b0;
    logic         RST;
    logic         RECEIVE_PC_VALID;
    logic [178:0] RECEIVE_PC_DATA;
    logic         RECEIVE_PC_READY;
    logic         SEND_WR_VALID;
    logic [66:0]  SEND_WR_DATA;
    logic         SEND_WR_READY;
    logic         MEM_SEND_ADDR_VALID;
    logic [31:0]  MEM_SEND_ADDR;
    logic         MEM_SEND_DATA_VALID;
    logic [31:0]  MEM_SEND_DATA;
    logic         MEM_SEND_READY;
    logic         MEM_RECEIVE_VALID;
    logic [31:0]  MEM_RECEIVE_DATA;
    logic         MEM_RECEIVE_READY;

    int checks   = 0;
    int failures = 0;
    int req_cnt  = 0;
    int wr_cnt   = 0;

    memory_accessor #(.MA_POKE(MA_POKE)) dut (
        .CLK                 (CLK),
        .RST                 (RST),
        .RECEIVE_PC_VALID    (RECEIVE_PC_VALID),
        .RECEIVE_PC_DATA     (RECEIVE_PC_DATA),
        .RECEIVE_PC_READY    (RECEIVE_PC_READY),
        .SEND_WR_VALID       (SEND_WR_VALID),
        .SEND_WR_DATA        (SEND_WR_DATA),
        .SEND_WR_READY       (SEND_WR_READY),
        .MEM_SEND_ADDR_VALID (MEM_SEND_ADDR_VALID),
        .MEM_SEND_ADDR       (MEM_SEND_ADDR),
        .MEM_SEND_DATA_VALID (MEM_SEND_DATA_VALID),
        .MEM_SEND_DATA       (MEM_SEND_DATA),
        .MEM_SEND_READY      (MEM_SEND_READY),
        .MEM_RECEIVE_VALID   (MEM_RECEIVE_VALID),
        .MEM_RECEIVE_DATA    (MEM_RECEIVE_DATA),
        .MEM_RECEIVE_READY   (MEM_RECEIVE_READY)
    );

    always #5 CLK = ~CLK;

    // Count handshakes on the memory-request and result channels
    always @(posedge CLK) begin
        if (MEM_SEND_ADDR_VALID && MEM_SEND_READY) req_cnt <= req_cnt + 1;
        if (SEND_WR_VALID && SEND_WR_READY) wr_cnt <= wr_cnt + 1;
    end

    // Global time limit so the run always ends
    initial begin
        #500000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [178:0] mk_pkt(input logic [9:0] subop, input logic [31:0] d1,
                                            input logic [31:0] d2, input logic [2:0] dopt,
                                            input logic [15:0] daddr, input logic [15:0] color);
        return {6'h2A, subop, d1, d2, 32'h3333_3333, 32'h4444_4444, dopt, daddr, color};
    endfunction

    // Full transaction; 'stall' cycles of backpressure on each of the three waits
    task automatic run_op(input logic [9:0] subop, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [2:0] dopt, input logic [15:0] daddr,
                          input logic [15:0] color, input logic [31:0] reply, input int stall);
        int          req0;
        int          wr0;
        int          n;
        logic        exp_poke;
        logic [66:0] exp_wr;
        exp_poke = (subop == MA_POKE);
        exp_wr   = {dopt, daddr, color, reply};
        n = 0;
        while (RECEIVE_PC_READY !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check("pc_ready_before_send", 67'(RECEIVE_PC_READY), 67'd1);
        req0 = req_cnt;
        wr0  = wr_cnt;
        RECEIVE_PC_VALID = 1'b1;
        RECEIVE_PC_DATA  = mk_pkt(subop, d1, d2, dopt, daddr, color);
        tick();
        RECEIVE_PC_VALID = 1'b0;
        RECEIVE_PC_DATA  = '1;
        check("req_addr_valid", 67'(MEM_SEND_ADDR_VALID), 67'd1);
        check("req_addr", 67'(MEM_SEND_ADDR), 67'(d1));
        check("req_data", 67'(MEM_SEND_DATA), 67'(d2));
        check("req_data_valid", 67'(MEM_SEND_DATA_VALID), 67'(exp_poke));
        check("req_pc_ready", 67'(RECEIVE_PC_READY), 67'd0);
        // Memory not ready; a stray reply must be ignored
        for (int i = 0; i < stall; i++) begin
            MEM_RECEIVE_VALID = 1'b1;
            MEM_RECEIVE_DATA  = 32'h0BAD_0BAD;
            tick();
            check("req_stall_valid", 67'({MEM_SEND_ADDR_VALID, MEM_SEND_DATA_VALID}),
                  67'({1'b1, exp_poke}));
            check("req_stall_addr", 67'(MEM_SEND_ADDR), 67'(d1));
            check("req_stall_rxready", 67'(MEM_RECEIVE_READY), 67'd0);
        end
        MEM_RECEIVE_VALID = 1'b0;
        MEM_SEND_READY    = 1'b1;
        tick();
        MEM_SEND_READY = 1'b0;
        check("wait_addr_valid", 67'({MEM_SEND_ADDR_VALID, MEM_SEND_DATA_VALID}), 67'd0);
        check("wait_rx_ready", 67'(MEM_RECEIVE_READY), 67'd1);
        // Reply withheld; a stray packet must be ignored
        for (int i = 0; i < stall; i++) begin
            RECEIVE_PC_VALID = 1'b1;
            tick();
            check("wait_stall_rx_ready", 67'(MEM_RECEIVE_READY), 67'd1);
            check("wait_stall_wr_valid", 67'(SEND_WR_VALID), 67'd0);
        end
        RECEIVE_PC_VALID  = 1'b0;
        MEM_RECEIVE_VALID = 1'b1;
        MEM_RECEIVE_DATA  = reply;
        tick();
        MEM_RECEIVE_VALID = 1'b0;
        MEM_RECEIVE_DATA  = 32'h0;
        check("res_wr_valid", 67'(SEND_WR_VALID), 67'd1);
        check("res_wr_data", SEND_WR_DATA, exp_wr);
        check("res_rx_ready", 67'(MEM_RECEIVE_READY), 67'd0);
        for (int i = 0; i < stall; i++) begin
            tick();
            check("res_stall_wr", {SEND_WR_VALID, SEND_WR_DATA[65:0]}, {1'b1, exp_wr[65:0]});
            check("res_stall_pc_ready", 67'(RECEIVE_PC_READY), 67'd0);
        end
        SEND_WR_READY = 1'b1;
        tick();
        SEND_WR_READY = 1'b0;
        check("done_wr_valid", 67'(SEND_WR_VALID), 67'd0);
        check("done_pc_ready", 67'(RECEIVE_PC_READY), 67'd1);
        check("one_mem_request", 67'(req_cnt - req0), 67'd1);
        check("one_result", 67'(wr_cnt - wr0), 67'd1);
    endtask

    initial begin
        logic [31:0] r_d1;
        logic [31:0] r_d2;
        logic [31:0] r_reply;
        logic [2:0]  r_dopt;
        logic [15:0] r_daddr;
        logic [15:0] r_color;
        int          wr_before;

        RST               = 1'b0;
        RECEIVE_PC_VALID  = 1'b0;
        RECEIVE_PC_DATA   = '0;
        SEND_WR_READY     = 1'b0;
        MEM_SEND_READY    = 1'b0;
        MEM_RECEIVE_VALID = 1'b0;
        MEM_RECEIVE_DATA  = 32'h0;

        // 1: reset state
        tick();
        check("rst_pc_ready", 67'(RECEIVE_PC_READY), 67'd0);
        check("rst_addr_valid", 67'(MEM_SEND_ADDR_VALID), 67'd0);
        check("rst_wr_valid", 67'(SEND_WR_VALID), 67'd0);
        check("rst_wr_data", SEND_WR_DATA, 67'd0);
        RST = 1'b1;
        tick();
        check("post_rst_pc_ready", 67'(RECEIVE_PC_READY), 67'd1);

        // 2: PEEK
        run_op(MA_PEEK, 32'h0000_1000, 32'h5555_AAAA, 3'd5, 16'h1234, 16'hBEEF,
               32'hCAFE_F00D, 0);
        // 3: POKE
        run_op(MA_POKE, 32'h0000_0020, 32'hDEAD_BEEF, 3'd2, 16'h00FF, 16'h0F0F,
               32'h1357_9BDF, 0);
        // Unknown subop is executed as PEEK
        run_op(10'h3FF, 32'hFFFF_FFFC, 32'h0000_0001, 3'd7, 16'hFFFF, 16'h0000,
               32'h0000_0000, 0);
        // 4: backpressure on every channel
        run_op(MA_POKE, 32'h8000_0004, 32'hA5A5_5A5A, 3'd1, 16'h4321, 16'hC0DE,
               32'hFEED_FACE, 5);
        run_op(MA_PEEK, 32'h0000_0040, 32'h0, 3'd3, 16'h0102, 16'h0304, 32'h89AB_CDEF, 5);

        // 5: alternating PEEK/POKE soak with random fields
        for (int k = 0; k < 100; k++) begin
            r_d1    = $urandom;
            r_d2    = $urandom;
            r_reply = $urandom;
            r_dopt  = 3'($urandom_range(7, 0));
            r_daddr = 16'($urandom);
            r_color = 16'($urandom);
            run_op(((k % 2) == 0) ? MA_PEEK : MA_POKE, r_d1, r_d2, r_dopt, r_daddr, r_color,
                   r_reply, (k % 7 == 0) ? 2 : 0);
        end

        // 6: reset while waiting for the reply
        wr_before        = wr_cnt;
        RECEIVE_PC_VALID = 1'b1;
        RECEIVE_PC_DATA  = mk_pkt(MA_POKE, 32'h0000_0100, 32'h0000_0200, 3'd6, 16'hAAAA,
                                  16'h5555);
        tick();
        RECEIVE_PC_VALID = 1'b0;
        MEM_SEND_READY   = 1'b1;
        tick();
        MEM_SEND_READY = 1'b0;
        check("abort_in_wait", 67'(MEM_RECEIVE_READY), 67'd1);
        RST = 1'b0;
        tick();
        check("abort_pc_ready", 67'(RECEIVE_PC_READY), 67'd0);
        check("abort_mem_outputs",
              67'({MEM_SEND_ADDR_VALID, MEM_SEND_DATA_VALID, MEM_RECEIVE_READY}), 67'd0);
        check("abort_addr_bus", 67'({MEM_SEND_ADDR, MEM_SEND_DATA}), 67'd0);
        check("abort_wr", {SEND_WR_VALID, SEND_WR_DATA[65:0]}, 67'd0);
        RST = 1'b1;
        MEM_RECEIVE_VALID = 1'b1;
        MEM_RECEIVE_DATA  = 32'h7777_7777;
        tick();
        MEM_RECEIVE_VALID = 1'b0;
        tick();
        check("abort_no_result", 67'({SEND_WR_VALID, 31'(wr_cnt - wr_before)}), 67'd0);
        run_op(MA_PEEK, 32'h0000_0300, 32'h0, 3'd4, 16'h0BB0, 16'h0CC0, 32'h2468_ACE0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
